// File: rtl/btn_conditioner_if.sv
// Button bundle between the board push-buttons and the controller: raw inputs in,
// debounced level and single-cycle event pulses out, plus the per-bit FSM state for observation.
interface btn_conditioner_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_hold;
    logic [NUM_BTN-1:0] btn_repeat;
    logic [NUM_BTN-1:0] btn_state;   // 1 = DOWN, 0 = IDLE

    // Events are plain single-cycle pulses with no back-pressure: the consumer must sample every cycle.
    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_hold, btn_repeat, btn_state
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_hold, btn_repeat, btn_state
    );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button synchroniser, debouncer and press/release/hold/auto-repeat event generator.
// Optional feature macro: BTN_AUTOREPEAT_EN enables the repeat phase and btn_repeat.
module btn_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000,
    parameter int CNT_W           = 27
) (
    input  logic             clk,
    input  logic             reset,
    btn_conditioner_if.slave bus
);

    localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 2) && (HOLD_CYCLES > DEBOUNCE_CYCLES) &&
                               (REPEAT_CYCLES >= 2) &&
                               (64'(HOLD_CYCLES) < (64'd1 << CNT_W)) &&
                               (64'(REPEAT_CYCLES) < (64'd1 << CNT_W));

    if (!PARAMS_OK) begin : g_bad_params
        $error("btn_conditioner: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic {
        IDLE = 1'b0,
        DOWN = 1'b1
    } state_e;

    state_e             state_q [NUM_BTN];
    state_e             state_d [NUM_BTN];
    logic [CNT_W-1:0]   deb_q   [NUM_BTN];
    logic [CNT_W-1:0]   deb_d   [NUM_BTN];
    logic [CNT_W-1:0]   hold_q  [NUM_BTN];
    logic [CNT_W-1:0]   hold_d  [NUM_BTN];
    logic [NUM_BTN-1:0] sync1, sync2, level;
    // long_q marks that the long-press event has already fired for the current press
    logic [NUM_BTN-1:0] long_q, long_d;
    logic [NUM_BTN-1:0] press_q, press_d, release_q, release_d, hold_ev_q, hold_ev_d;
`ifdef BTN_AUTOREPEAT_EN
    logic [NUM_BTN-1:0] repeat_q, repeat_d;
`endif

    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            level[i] = (state_q[i] == DOWN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            long_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            hold_ev_q <= '0;
`ifdef BTN_AUTOREPEAT_EN
            repeat_q  <= '0;
`endif
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= IDLE;
                deb_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            sync1     <= bus.btn_raw;
            sync2     <= sync1;
            long_q    <= long_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_ev_q <= hold_ev_d;
`ifdef BTN_AUTOREPEAT_EN
            repeat_q  <= repeat_d;
`endif
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                deb_q[i]   <= deb_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    always_comb begin
        long_d    = long_q;
        press_d   = '0;
        release_d = '0;
        hold_ev_d = '0;
`ifdef BTN_AUTOREPEAT_EN
        repeat_d  = '0;
`endif
        for (int i = 0; i < NUM_BTN; i++) begin
            logic acc;
            state_d[i] = state_q[i];
            deb_d[i]   = deb_q[i];
            hold_d[i]  = hold_q[i];
            acc        = 1'b0;

            if (sync2[i] == level[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] == DEB_LAST) begin
                deb_d[i] = '0;
                acc      = 1'b1;
            end else begin
                deb_d[i] = deb_q[i] + 1'b1;
            end

            case (state_q[i])
                IDLE: begin
                    hold_d[i] = '0;
                    long_d[i] = 1'b0;
                    if (acc) begin
                        state_d[i] = DOWN;
                        press_d[i] = 1'b1;
                    end
                end
                DOWN: begin
                    // An accepted fall takes priority over any hold/repeat due this cycle
                    if (acc) begin
                        state_d[i]   = IDLE;
                        release_d[i] = 1'b1;
                        hold_d[i]    = '0;
                        long_d[i]    = 1'b0;
                    end else if (!long_q[i]) begin
                        if (hold_q[i] == HOLD_LAST) begin
                            hold_ev_d[i] = 1'b1;
                            long_d[i]    = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            hold_d[i]    = '0;
`endif
                        end else begin
                            hold_d[i] = hold_q[i] + 1'b1;
                        end
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (hold_q[i] == REP_LAST) begin
                        repeat_d[i] = 1'b1;
                        hold_d[i]   = '0;
                    end else begin
                        hold_d[i] = hold_q[i] + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.btn_level   = level;
    assign bus.btn_state   = level;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_hold    = hold_ev_q;
`ifdef BTN_AUTOREPEAT_EN
    assign bus.btn_repeat  = repeat_q;
`else
    assign bus.btn_repeat  = '0;
`endif

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end button conditioner for the timekeeper. It sits between the raw board push-buttons and the mode/edit/timer controller. Each button is synchronised and debounced independently, and the block emits single-cycle press, release, hold and auto-repeat events. The controller consumes these events in place of counting button-held cycles itself.

## Interface
Parameters:
- NUM_BTN, 4, number of buttons; bit map 0=start_stop, 1=mode, 2=edit_shift, 3=inc
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (>=2)
- HOLD_CYCLES, 100_000_000, cycles after press before the long-press event (>DEBOUNCE_CYCLES)
- REPEAT_CYCLES, 25_000_000, auto-repeat period after the long-press event (>=2)
- CNT_W, 27, counter width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high; clears all state
- btn_raw  in  NUM_BTN  raw asynchronous button inputs, active-high
- btn_level  out  NUM_BTN  debounced level
- btn_press  out  NUM_BTN  1-cycle pulse on debounced rising edge
- btn_release  out  NUM_BTN  1-cycle pulse on debounced falling edge
- btn_hold  out  NUM_BTN  1-cycle pulse, once per press, after HOLD_CYCLES
- btn_repeat  out  NUM_BTN  1-cycle pulse every REPEAT_CYCLES after hold, while held

## Operation
- Per bit: 2-flop synchroniser (sync1, sync2), debounce counter, hold counter, 2-state FSM: IDLE (level 0) / DOWN (level 1).
- Debounce: if sync2 == level, the debounce counter clears. Otherwise it increments. When the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, level toggles and the counter clears.
- Any glitch shorter than DEBOUNCE_CYCLES cycles at sync2 is discarded.
- IDLE->DOWN on accepted rise: btn_press=1 that cycle. DOWN->IDLE on accepted fall: btn_release=1 that cycle.
- Hold counter clears in IDLE and increments each cycle in DOWN.
- At count HOLD_CYCLES-1, btn_hold pulses and the counter reloads to 0 in repeat phase. In repeat phase, btn_repeat pulses each time the count reaches REPEAT_CYCLES-1, then reloads.
- On release: the counter clears and no further hold/repeat pulses occur. A release pulse can never coincide with a hold or repeat pulse on the same bit; release wins.
- Bits are fully independent. Simultaneous presses produce simultaneous pulses.
- All outputs are registered.

## Timing
- Reset values: btn_level, btn_press, btn_release, btn_hold, btn_repeat = 0. Synchronisers, counters and FSMs are cleared (IDLE).
- Press latency: a raw rise stable from edge 0 shows btn_level=1 and btn_press=1 after edge 2+DEBOUNCE_CYCLES. Release latency is the same.
- btn_hold arrives HOLD_CYCLES cycles after btn_press. The first btn_repeat arrives REPEAT_CYCLES after btn_hold, then every REPEAT_CYCLES.
- Button held through reset deassertion: level starts at 0, so a normal press is emitted 2+DEBOUNCE_CYCLES after reset release.
- Reset asserted mid-press: all outputs drop immediately (asynchronous). No release pulse is emitted.
- Counters never wrap past their terminal values. CNT_W overflow is prohibited by parameter rule.

## Configuration
- BTN_AUTOREPEAT_EN defined: repeat phase and btn_repeat behave as above.
- BTN_AUTOREPEAT_EN undefined:
  - btn_repeat is tied 0.
  - After btn_hold, the hold counter saturates and stays quiet until release.
  - Repeat logic is not synthesised.

## Test plan
Use NUM_BTN=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8, with BTN_AUTOREPEAT_EN defined unless noted.
- Clean press: btn_raw[1] 0->1 at edge 0, held 10 cycles -> btn_level[1]=1 and btn_press[1] 1-cycle pulse after edge 6. No other bits change.
- Bounce: btn_raw[3] toggles 1,0,1,0 on single cycles, then stays 1 -> no pulse during bouncing. Exactly one btn_press[3], arriving 6 cycles after the final stable rise.
- Long hold: btn_raw[3] held 60 cycles -> btn_press at edge 6, btn_hold at edge 22, btn_repeat at edges 30, 38, 46, 54, 62. After raw falls, exactly one btn_release 6 cycles later.
- Macro off: same stimulus as long hold -> btn_hold at edge 22 and btn_repeat stays 0 throughout.
- Reset mid-hold: reset asserted for 3 cycles at edge 25 while btn_raw[0] is held -> all outputs 0 asynchronously, no release pulse. After reset drops, btn_press[0] arrives 6 cycles later.
- Simultaneous: btn_raw[0] and btn_raw[2] rise on the same edge -> btn_press[0] and btn_press[2] pulse in the same cycle; their releases are independent.
